// File: rtl/led_pattern_engine_if.sv
// Request/response channel between the LED serialiser and the pattern engine.
// The serialiser is the master; the engine is the slave.
interface led_pattern_engine_if #(
    parameter int IDX_W = 8,
    parameter int COL_W = 8
);
    logic             req_valid;
    logic             req_ready;
    logic [IDX_W-1:0] req_index;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [IDX_W-1:0] rsp_index;
    logic [COL_W-1:0] red;
    logic [COL_W-1:0] green;
    logic [COL_W-1:0] blue;

    modport master (
        output req_valid, req_index, rsp_ready,
        input  req_ready, rsp_valid, rsp_index, red, green, blue
    );

    modport slave (
        input  req_valid, req_index, rsp_ready,
        output req_ready, rsp_valid, rsp_index, red, green, blue
    );
endinterface

// File: rtl/led_pattern_engine.sv
// Per-LED colour engine: animation timebase, pattern generator, gain crossfade,
// and a 2-stage stallable request/response pipeline.
module led_pattern_engine #(
    parameter int NUM_LEDS  = 49,
    parameter int IDX_W     = 8,
    parameter int COL_W     = 8,
    parameter int CNT_W     = 33,
    parameter int FADE_STEP = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            mode_in,
    input  logic                  mode_load,
    led_pattern_engine_if.slave   bus,
    output logic                  busy_fade
);
    typedef enum logic [1:0] {RUN, FADE_OUT, FADE_IN} state_t;

    localparam logic [COL_W-1:0] FS    = '1;
    localparam logic [8:0]       G_MAX = 9'd256;
    localparam logic [8:0]       STEP  = 9'(FADE_STEP);
    localparam logic [IDX_W:0]   LEDS  = (IDX_W+1)'(NUM_LEDS);

    logic [CNT_W-1:0] r_count;
    state_t           r_state, w_next_state;
    logic [8:0]       r_gain, w_next_gain;
    logic [2:0]       r_active, w_next_active;
    logic [2:0]       r_pending, w_next_pending;

    logic             w_tick;
    logic [7:0]       w_anim;
    logic [7:0]       w_bounce;
    logic [1:0]       w_step2;
    logic [1:0]       w_pal;
    logic             w_en;
    logic [COL_W-1:0] w_raw_r, w_raw_g, w_raw_b;

    logic             r_s1_valid;
    logic [IDX_W-1:0] r_s1_index;
    logic [COL_W-1:0] r_s1_r, r_s1_g, r_s1_b;
    logic             r_rsp_valid;
    logic [IDX_W-1:0] r_rsp_index;
    logic [COL_W-1:0] r_red, r_green, r_blue;

    // Proximity of the moving block at position p to this LED, 0..255.
    function automatic logic [COL_W-1:0] prox(input logic [7:0] p,
                                              input logic [IDX_W-1:0] idx);
        logic [IDX_W+7:0] frac, base, d;
        logic [7:0]       v;
        frac = (IDX_W+8)'(p) * (IDX_W+8)'(NUM_LEDS);
        base = {idx, 8'h00};
        d    = (frac >= base) ? frac - base : base - frac;
        if (d >= 1024)
            v = 8'd0;
        else if (d <= 8)
            v = 8'd255;
        else
            v = 8'(9'd256 - 9'(d >> 2));
        return COL_W'({v, {COL_W{1'b0}}} >> 8);
    endfunction

    function automatic logic [COL_W-1:0] scale(input logic [COL_W-1:0] c,
                                               input logic [8:0] g);
        return COL_W'(((COL_W+9)'(c) * (COL_W+9)'(g)) >> 8);
    endfunction

    assign w_anim   = r_count[CNT_W-5 -: 8];
    assign w_step2  = r_count[CNT_W-7 -: 2];
    assign w_tick   = &r_count[CNT_W-13:0];
    assign w_pal    = w_step2 + bus.req_index[1:0];
    assign w_bounce = w_anim[7] ? {~w_anim[6:0], 1'b0} : {w_anim[6:0], 1'b0};

    assign w_en          = !r_rsp_valid || bus.rsp_ready;
    assign bus.req_ready = w_en;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_index = r_rsp_index;
    assign bus.red       = r_red;
    assign bus.green     = r_green;
    assign bus.blue      = r_blue;
    assign busy_fade     = (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_count <= '0;
        else
            r_count <= r_count + 1'b1;
    end

    always_comb begin
        w_raw_r = '0;
        w_raw_g = '0;
        w_raw_b = '0;
        if ({1'b0, bus.req_index} < LEDS) begin
            case (r_active)
                3'd0: begin
                    unique case (w_pal)
                        2'd0: w_raw_r = FS;
                        2'd1: w_raw_g = FS;
                        2'd2: w_raw_b = FS;
                        2'd3: begin
                            w_raw_r = FS;
                            w_raw_g = FS;
                        end
                    endcase
                end
                3'd1: w_raw_b = prox(w_anim, bus.req_index);
                3'd2: w_raw_g = prox(w_bounce, bus.req_index);
                3'd3: begin
                    w_raw_r = FS >> 2;
                    w_raw_g = FS >> 2;
                    w_raw_b = FS >> 2;
                end
                default: ;
            endcase
        end
    end

    // A mode_load that changes state wins over a coincident tick.
    always_comb begin
        w_next_state   = r_state;
        w_next_gain    = r_gain;
        w_next_active  = r_active;
        w_next_pending = r_pending;
        unique case (r_state)
            RUN: begin
                if (mode_load && mode_in != r_active) begin
                    w_next_pending = mode_in;
                    w_next_state   = FADE_OUT;
                end
            end
            FADE_OUT: begin
                if (mode_load)
                    w_next_pending = mode_in;
                if (w_tick) begin
                    if (r_gain <= STEP) begin
                        w_next_gain   = '0;
                        w_next_active = w_next_pending;
                        w_next_state  = FADE_IN;
                    end else begin
                        w_next_gain = r_gain - STEP;
                    end
                end
            end
            FADE_IN: begin
                if (mode_load && mode_in != r_active) begin
                    w_next_pending = mode_in;
                    w_next_state   = FADE_OUT;
                end else if (w_tick) begin
                    if (r_gain >= G_MAX - STEP) begin
                        w_next_gain  = G_MAX;
                        w_next_state = RUN;
                    end else begin
                        w_next_gain = r_gain + STEP;
                    end
                end
            end
            default: w_next_state = RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= RUN;
            r_gain    <= G_MAX;
            r_active  <= '0;
            r_pending <= '0;
        end else begin
            r_state   <= w_next_state;
            r_gain    <= w_next_gain;
            r_active  <= w_next_active;
            r_pending <= w_next_pending;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_index  <= '0;
            r_s1_r      <= '0;
            r_s1_g      <= '0;
            r_s1_b      <= '0;
            r_rsp_valid <= 1'b0;
            r_rsp_index <= '0;
            r_red       <= '0;
            r_green     <= '0;
            r_blue      <= '0;
        end else if (w_en) begin
            r_s1_valid  <= bus.req_valid;
            r_rsp_valid <= r_s1_valid;
            if (bus.req_valid) begin
                r_s1_index <= bus.req_index;
                r_s1_r     <= w_raw_r;
                r_s1_g     <= w_raw_g;
                r_s1_b     <= w_raw_b;
            end
            if (r_s1_valid) begin
                r_rsp_index <= r_s1_index;
                r_red       <= scale(r_s1_r, r_gain);
                r_green     <= scale(r_s1_g, r_gain);
                r_blue      <= scale(r_s1_b, r_gain);
            end
        end
    end
endmodule

// File: tb/tb_led_pattern_engine.sv
// Bench for led_pattern_engine: directed bursts, fades, stall and reset,
// plus randomized traffic scored against a spec-level reference model.
module tb_led_pattern_engine;
    localparam int CNT_W = 16;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] mode_in;
    logic       mode_load;
    logic       busy_fade;

    led_pattern_engine_if #(.IDX_W(8), .COL_W(8)) bus ();

    led_pattern_engine #(
        .NUM_LEDS(49), .IDX_W(8), .COL_W(8), .CNT_W(CNT_W), .FADE_STEP(16)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mode_in   (mode_in),
        .mode_load (mode_load),
        .bus       (bus),
        .busy_fade (busy_fade)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cnt   = 0;
    int cyc   = 0;
    int n_acc = 0;
    int m_st, m_gain, m_act, m_pend;
    int ghist[int];

    typedef struct {
        int idx;
        int raw;
        int t;
    } item_t;
    item_t q[$];

    logic [7:0]  bix[4];
    logic [23:0] bex[4];
    logic [7:0]  six[6];

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int prox_m(int p, int idx);
        int d;
        d = p * 49 - idx * 256;
        if (d < 0) d = -d;
        if (d >= 1024) return 0;
        if (d <= 8) return 255;
        return 256 - d / 4;
    endfunction

    // Returns {r,g,b} packed as 24 bits.
    function automatic int raw_m(int mode, int idx, int c);
        int anim, step, b;
        anim = (c >> 4) & 255;
        step = (c >> 8) & 255;
        if (idx >= 49) return 0;
        case (mode)
            0: case ((step + idx) % 4)
                   0: return 32'hFF0000;
                   1: return 32'h00FF00;
                   2: return 32'h0000FF;
                   default: return 32'hFFFF00;
               endcase
            1: return prox_m(anim, idx);
            2: begin
                b = (anim < 128) ? anim * 2 : (255 - anim) * 2;
                return prox_m(b, idx) << 8;
            end
            3: return 32'h3F3F3F;
            default: return 0;
        endcase
    endfunction

    function automatic int scale_m(int raw, int g);
        int r, gr, b;
        r  = (((raw >> 16) & 255) * g) >> 8;
        gr = (((raw >> 8) & 255) * g) >> 8;
        b  = ((raw & 255) * g) >> 8;
        return (r << 16) | (gr << 8) | b;
    endfunction

    // One clock: score the handshakes of this cycle, advance the model.
    task automatic cycle(input int want_ready);
        bit tk;
        #1;
        ghist[cyc] = m_gain;
        if (want_ready >= 0)
            chk("req_ready", bus.req_ready, want_ready);
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0) begin
                chk("rsp_extra", 1, 0);
            end else begin
                item_t e;
                e = q.pop_front();
                chk("rsp", {bus.rsp_index, bus.red, bus.green, bus.blue},
                    {8'(e.idx), 24'(scale_m(e.raw, ghist[e.t+1]))});
            end
        end
        if (bus.req_valid && bus.req_ready) begin
            q.push_back('{idx: int'(bus.req_index),
                          raw: raw_m(m_act, int'(bus.req_index), cnt),
                          t: cyc});
            n_acc++;
        end
        tk = (cnt % 16) == 15;
        if (m_st == 0) begin
            if (mode_load && int'(mode_in) != m_act) begin
                m_pend = mode_in;
                m_st   = 1;
            end
        end else if (m_st == 1) begin
            if (mode_load) m_pend = mode_in;
            if (tk) begin
                m_gain = (m_gain > 16) ? m_gain - 16 : 0;
                if (m_gain == 0) begin
                    m_act = m_pend;
                    m_st  = 2;
                end
            end
        end else begin
            if (mode_load && int'(mode_in) != m_act) begin
                m_pend = mode_in;
                m_st   = 1;
            end else if (tk) begin
                m_gain = (m_gain + 16 > 256) ? 256 : m_gain + 16;
                if (m_gain == 256) m_st = 0;
            end
        end
        cnt = (cnt + 1) % 65536;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n         = 1'b0;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        mode_load     = 1'b0;
        #1;
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_busy", busy_fade, 0);
        chk("rst_outputs", {bus.rsp_index, bus.red, bus.green, bus.blue}, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n  = 1'b1;
        cnt    = 0;
        m_st   = 0;
        m_gain = 256;
        m_act  = 0;
        m_pend = 0;
        q.delete();
    endtask

    task automatic burst4(input string tag);
        for (int k = 0; k < 8; k++) begin
            bus.rsp_ready = 1'b1;
            bus.req_valid = (k < 4);
            if (k < 4) bus.req_index = bix[k];
            chk({tag, "_valid"}, bus.rsp_valid, (k >= 2 && k <= 5));
            if (k >= 2 && k <= 5)
                chk(tag, {bus.rsp_index, bus.red, bus.green, bus.blue},
                    {bix[k-2], bex[k-2]});
            cycle(-1);
        end
    endtask

    task automatic drain();
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        repeat (4) cycle(-1);
        chk("drain_empty", q.size(), 0);
    endtask

    task automatic rand_stream(input int n);
        for (int i = 0; i < n; i++) begin
            bus.req_valid = ($urandom % 10) < 6;
            bus.req_index = 8'($urandom_range(0, 60));
            bus.rsp_ready = ($urandom % 10) < 7;
            cycle(-1);
        end
        drain();
    endtask

    task automatic load_mode(input int m);
        mode_in       = 3'(m);
        mode_load     = 1'b1;
        bus.req_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        cycle(-1);
        mode_load = 1'b0;
        chk("busy_on", busy_fade, 1);
    endtask

    task automatic stream_one();
        bus.req_valid = $urandom % 2;
        bus.req_index = 8'($urandom_range(0, 52));
        bus.rsp_ready = 1'b1;
        chk("busy_fade", busy_fade, (m_st != 0));
        cycle(-1);
    endtask

    task automatic fade_wait();
        for (int i = 0; i < 1200 && m_st != 0; i++)
            stream_one();
        if (m_st != 0) chk("fade_timeout", 1, 0);
        chk("busy_off", busy_fade, 0);
        drain();
    endtask

    initial begin
        int sent0;
        rst_n         = 1'b1;
        mode_in       = 3'd0;
        mode_load     = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_index = '0;
        bus.rsp_ready = 1'b1;
        #2;
        do_reset();

        bix = '{8'd0, 8'd1, 8'd2, 8'd3};
        bex = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00};
        burst4("palette");

        load_mode(1);
        fade_wait();

        for (int i = 0; i < 4200 && (cnt % 4096) != 0; i++)
            cycle(-1);
        bix = '{8'd0, 8'd1, 8'd4, 8'd49};
        bex = '{24'h0000FF, 24'h0000C0, 24'h000000, 24'h000000};
        burst4("running");
        rand_stream(200);

        load_mode(2);
        fade_wait();
        rand_stream(400);

        six   = '{8'd3, 8'd10, 8'd20, 8'd30, 8'd40, 8'd48};
        sent0 = n_acc;
        for (int k = 0; k < 13; k++) begin
            bus.req_valid = (n_acc - sent0) < 6;
            if ((n_acc - sent0) < 6) bus.req_index = six[n_acc - sent0];
            bus.rsp_ready = !(k >= 2 && k <= 6);
            if (k >= 2 && k <= 6) begin
                chk("stall_valid", bus.rsp_valid, 1);
                chk("stall_hold", {bus.rsp_index, bus.red, bus.green, bus.blue},
                    {8'(q[0].idx), 24'(scale_m(q[0].raw, 256))});
            end
            if (k >= 7) chk("no_gap", bus.rsp_valid, 1);
            cycle((k >= 2 && k <= 6) ? 0 : -1);
        end
        chk("stall_sent", n_acc - sent0, 6);
        drain();

        load_mode(1);
        for (int i = 0; i < 1200 && !(m_st == 2 && m_gain == 64
                                       && (cnt % 16) != 15); i++)
            stream_one();
        chk("reached_fadein_64", (m_st == 2 && m_gain == 64), 1);
        drain();
        load_mode(3);
        fade_wait();
        bix = '{8'd0, 8'd10, 8'd48, 8'd49};
        bex = '{24'h3F3F3F, 24'h3F3F3F, 24'h3F3F3F, 24'h000000};
        burst4("solid");

        load_mode(0);
        repeat (40) cycle(-1);
        bus.req_valid = 1'b1;
        bus.req_index = 8'd5;
        cycle(-1);
        bus.req_index = 8'd6;
        cycle(-1);
        bus.req_valid = 1'b0;
        chk("inflight", bus.rsp_valid, 1);
        do_reset();
        bix = '{8'd0, 8'd1, 8'd2, 8'd3};
        bex = '{24'hFF0000, 24'h00FF00, 24'h0000FF, 24'hFFFF00};
        burst4("post_reset");
        chk("post_reset_busy", busy_fade, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
